// File: rtl/grid_draw_sequencer.sv
// Grid-line sequencer: runs the horizontal then vertical line drawers once per start
// request and turns their local counts into registered VGA plot writes.
module grid_draw_sequencer #(
    parameter logic [7:0] ORIGIN_X  = 8'd20,
    parameter logic [6:0] ORIGIN_Y  = 7'd10,
    parameter logic [4:0] PITCH     = 5'd2,
    parameter logic [3:0] NUM_LINES = 4'd10,
    parameter logic [2:0] THICK_COL = 3'b000,
    parameter logic [2:0] THIN_COL  = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] h_x,
    input  logic [1:0] h_y,
    input  logic       h_done,
    input  logic [1:0] v_x,
    input  logic [4:0] v_y,
    input  logic       v_done,
    output logic       h_enable,
    output logic       v_enable,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_H_LINE,
        S_H_GAP,
        S_V_LINE,
        S_V_GAP,
        S_FINISH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;

    logic [7:0] offset;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_col;

    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic [2:0] colour_q;
    logic       plot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_H_LINE;
                    idx_d   = 4'd0;
                end
            end
            S_H_LINE: if (h_done) state_d = S_H_GAP;
            S_H_GAP: begin
                if (idx_q < NUM_LINES - 4'd1) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_H_LINE;
                end else begin
                    idx_d   = 4'd0;
                    state_d = S_V_LINE;
                end
            end
            S_V_LINE: if (v_done) state_d = S_V_GAP;
            S_V_GAP: begin
                if (idx_q < NUM_LINES - 4'd1) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_V_LINE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Enables drop for a whole gap cycle so the drawers clear their counts between lines.
    always_comb begin
        h_enable = 1'b0;
        v_enable = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_H_LINE: begin h_enable = 1'b1; busy = 1'b1; end
            S_H_GAP:  busy = 1'b1;
            S_V_LINE: begin v_enable = 1'b1; busy = 1'b1; end
            S_V_GAP:  busy = 1'b1;
            S_FINISH: done = 1'b1;
            default:  ;
        endcase
    end

    assign offset  = {4'd0, idx_q} * {3'd0, PITCH};
    assign pix_col = (idx_q % 4'd3 == 4'd0) ? THICK_COL : THIN_COL;

    always_comb begin
        pix_valid = 1'b0;
        pix_x     = vga_x_q;
        pix_y     = vga_y_q;
        if (state_q == S_H_LINE) begin
            pix_valid = !h_done;
            pix_x     = ORIGIN_X + {3'd0, h_x};
            pix_y     = ORIGIN_Y + offset[6:0] + {5'd0, h_y};
        end else if (state_q == S_V_LINE) begin
            pix_valid = !v_done;
            pix_x     = ORIGIN_X + offset + {6'd0, v_x};
            pix_y     = ORIGIN_Y + {2'd0, v_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x_q  <= 8'd0;
            vga_y_q  <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= pix_valid;
            if (pix_valid) begin
                vga_x_q  <= pix_x;
                vga_y_q  <= pix_y;
                colour_q <= pix_col;
            end
        end
    end

    assign vga_x  = vga_x_q;
    assign vga_y  = vga_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: tb/tb_grid_draw_sequencer.sv
// Bench for grid_draw_sequencer: behavioural drawers, a plot log, and a reference
// grid built directly from the line geometry.
module tb_grid_draw_sequencer;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [4:0] h_x;
    logic [1:0] h_y;
    logic       h_done;
    logic [1:0] v_x;
    logic [4:0] v_y;
    logic       v_done;
    logic       h_enable, v_enable, plot, busy, done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;

    always #5 clk = ~clk;

    grid_draw_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .h_x(h_x), .h_y(h_y), .h_done(h_done),
        .v_x(v_x), .v_y(v_y), .v_done(v_done),
        .h_enable(h_enable), .v_enable(v_enable),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    // Behavioural drawers: count 0..LAST while enabled, done the cycle after LAST.
    logic [4:0] hc, vc;
    always @(posedge clk) begin
        if (!h_enable) begin hc <= 5'd0; h_done <= 1'b0; end
        else if (hc == 5'd16) h_done <= 1'b1;
        else hc <= hc + 5'd1;
        if (!v_enable) begin vc <= 5'd0; v_done <= 1'b0; end
        else if (vc == 5'd18) v_done <= 1'b1;
        else vc <= vc + 5'd1;
    end
    assign h_x = hc;
    assign h_y = 2'd0;
    assign v_x = 2'd0;
    assign v_y = vc;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int         n;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } vec_t;

    pix_t log_q[$];
    pix_t exp_q[$];
    int   overlap_cnt = 0;
    int   done_cnt    = 0;
    int   busy_cycles = 0;
    int   gap_cycles  = 0;
    int   compared    = 0;
    int   mismatched  = 0;

    always @(negedge clk) begin
        if (plot) log_q.push_back('{vga_x, vga_y, colour});
        if (h_enable && v_enable) overlap_cnt++;
        if (done) done_cnt++;
        if (busy) busy_cycles++;
        if (busy && !h_enable && !v_enable) gap_cycles++;
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic void build_expected();
        exp_q.delete();
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 17; k++)
                exp_q.push_back('{8'(20 + k), 7'(10 + 2 * i), (i % 3 == 0) ? 3'b000 : 3'b111});
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 19; k++)
                exp_q.push_back('{8'(20 + 2 * i), 7'(10 + k), (i % 3 == 0) ? 3'b000 : 3'b111});
    endfunction

    function automatic void clear_stats();
        log_q.delete();
        overlap_cnt = 0;
        done_cnt    = 0;
        busy_cycles = 0;
        gap_cycles  = 0;
    endfunction

    // One full grid draw; optional random spurious start pulses while busy.
    task automatic run_grid(input string tag, input bit spurious);
        int busy_low = 0;
        int cyc = 0;
        int bad = 0;
        clear_stats();
        repeat ($urandom_range(0, 5)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 2000) begin
            if (!busy) busy_low++;
            start = spurious && ($urandom_range(0, 19) == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_reached"}, int'(done), 1);
        check({tag, " busy_at_done"}, int'(busy), 0);
        repeat (4) @(negedge clk);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_drops"}, busy_low, 0);
        check({tag, " enable_overlap"}, overlap_cnt, 0);
        check({tag, " busy_cycles"}, busy_cycles, 400);
        check({tag, " gap_cycles"}, gap_cycles, 20);
        check({tag, " plot_count"}, log_q.size(), 360);
        for (int i = 0; i < 360 && i < log_q.size(); i++) begin
            if (log_q[i] != exp_q[i]) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL %s pixel %0d: actual (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                             tag, i, log_q[i].x, log_q[i].y, log_q[i].c,
                             exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
        compared++;
        if (bad != 0) mismatched++;
        $display("grid %s: %0d plots, %0d pixel errors, %0d done pulses", tag, log_q.size(), bad, done_cnt);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0,   8'd20, 7'd10, 3'b000};
        vecs[1] = '{16,  8'd36, 7'd10, 3'b000};
        vecs[2] = '{17,  8'd20, 7'd12, 3'b111};
        vecs[3] = '{51,  8'd20, 7'd16, 3'b000};
        vecs[4] = '{169, 8'd36, 7'd28, 3'b000};
        vecs[5] = '{170, 8'd20, 7'd10, 3'b000};
        vecs[6] = '{189, 8'd22, 7'd10, 3'b111};
        vecs[7] = '{341, 8'd38, 7'd10, 3'b000};
        vecs[8] = '{359, 8'd38, 7'd28, 3'b000};
        build_expected();

        // Reset held 3 cycles with start asserted: start must be ignored.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst plot", int'(plot), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst h_enable", int'(h_enable), 0);
        check("rst v_enable", int'(v_enable), 0);
        check("rst xy_colour", int'({vga_x, vga_y, colour}), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_reset ignored", int'(busy), 0);
        $display("reset: plot=%0d busy=%0d", plot, busy);

        run_grid("plain", 1'b0);
        foreach (vecs[i]) begin
            if (vecs[i].n < log_q.size()) begin
                check($sformatf("vec%0d x", i), log_q[vecs[i].n].x, vecs[i].x);
                check($sformatf("vec%0d y", i), log_q[vecs[i].n].y, vecs[i].y);
                check($sformatf("vec%0d c", i), log_q[vecs[i].n].c, vecs[i].c);
            end else begin
                check($sformatf("vec%0d present", i), log_q.size(), vecs[i].n + 1);
            end
        end

        // Start re-pulsed mid H_LINE must not disturb the sequence.
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("midline h_enable", int'(h_enable), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int cyc = 0;
            while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
            check("repulse done_reached", int'(done), 1);
        end
        repeat (2) @(negedge clk);
        check("repulse plot_count", log_q.size(), 360);
        check("repulse sequence", int'(log_q == exp_q), 1);
        $display("grid repulse: %0d plots", log_q.size());

        for (int r = 0; r < 3; r++) run_grid($sformatf("rand%0d", r), 1'b1);

        // Reset during V line idx 4 aborts; a fresh start redraws from H line 0.
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int cyc = 0;
            while (log_q.size() < 170 + 4 * 19 + 5 && cyc < 2000) begin @(negedge clk); cyc++; end
            check("abort reached_vline4", int'(v_enable), 1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort plot", int'(plot), 0);
        check("abort h_enable", int'(h_enable), 0);
        check("abort v_enable", int'(v_enable), 0);
        check("abort busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        $display("abort: plot=%0d busy=%0d v_enable=%0d", plot, busy, v_enable);
        run_grid("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
